// File: rtl/act_lane_arbiter_if.sv
// act_lane_arbiter_if
//   Bundles the lane-side request bus and the activation-side output stream
//   of act_lane_arbiter.
//   slave  : seen by the arbiter (takes lane beats, drives the act stream)
//   master : seen by the environment (drives lane beats, takes the act stream)
//   Lane k's data/address sit at [k*WIDTH +: WIDTH] of the packed vectors.
interface act_lane_arbiter_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NUM_LANES     = 4
);
  localparam int LANE_W = $clog2(NUM_LANES);

  logic [NUM_LANES-1:0]               lane_valid_i;
  logic [NUM_LANES-1:0]               lane_ready_o;
  logic [NUM_LANES-1:0]               lane_last_i;
  logic [NUM_LANES*DATA_WIDTH-1:0]    lane_data_i;
  logic [NUM_LANES*ADDRESS_WIDTH-1:0] lane_addr_i;

  logic                               act_valid_o;
  logic                               act_ready_i;
  logic                               act_last_o;
  logic [DATA_WIDTH-1:0]              act_data_o;
  logic [ADDRESS_WIDTH-1:0]           act_addr_o;
  logic [LANE_W-1:0]                  act_lane_o;

  modport slave (
    input  lane_valid_i, lane_last_i, lane_data_i, lane_addr_i, act_ready_i,
    output lane_ready_o, act_valid_o, act_last_o, act_data_o, act_addr_o, act_lane_o
  );

  modport master (
    output lane_valid_i, lane_last_i, lane_data_i, lane_addr_i, act_ready_i,
    input  lane_ready_o, act_valid_o, act_last_o, act_data_o, act_addr_o, act_lane_o
  );
endinterface

// File: rtl/act_lane_arbiter.sv
// act_lane_arbiter
//   Shares one activation unit between NUM_LANES accumulator lanes. Whole
//   bursts are granted round-robin and forwarded beat by beat through a single
//   registered valid/ready stage. Also tracks per-frame completion.
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   start_i      one-cycle pulse starting a new frame
//   bus          lane request bus + activation output stream (slave modport)
//   busy_o       high while a burst is granted or an output beat is pending
//   frame_done_o one-cycle pulse once every lane has delivered a last beat
//   beat_cnt_o   lane beats accepted since the last start_i (saturating)
module act_lane_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 10,
  parameter int NUM_LANES     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  act_lane_arbiter_if.slave        bus,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic [ADDRESS_WIDTH-1:0] beat_cnt_o
);
  localparam int LANE_W = $clog2(NUM_LANES);

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, next_state;
  logic [LANE_W-1:0]    rr_ptr, grant, pick;
  logic                 found;
  int                   idx;
  logic [NUM_LANES-1:0] done_mask, done_mask_next, grant_onehot;
  logic                 stage_free, accept, accept_last;

  // The output register can take a new beat when it is empty or draining.
  assign stage_free   = !bus.act_valid_o || bus.act_ready_i;
  assign accept       = (state == BURST) && bus.lane_valid_i[grant] && stage_free;
  assign accept_last  = accept && bus.lane_last_i[grant];
  assign grant_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << grant;
  assign busy_o       = (state == BURST) || bus.act_valid_o;

  // First requesting lane at or after rr_ptr, wrapping modulo NUM_LANES
  // (NUM_LANES need not be a power of two).
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_LANES;
      if (!found && bus.lane_valid_i[idx]) begin
        pick  = LANE_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|bus.lane_valid_i) next_state = BURST;
      BURST:   if (accept_last)       next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Only the granted lane is ever offered ready, even while it has dropped
  // valid: the grant stays locked until that lane's last beat.
  always_comb begin
    bus.lane_ready_o = '0;
    if (state == BURST) bus.lane_ready_o[grant] = stage_free;
  end

  // Grant is chosen in IDLE (one bubble cycle per burst); the pointer moves
  // past the granted lane only when its burst completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && found) grant <= pick;
      if (accept_last)
        rr_ptr <= (grant == LANE_W'(NUM_LANES-1)) ? '0 : grant + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.act_valid_o <= 1'b0;
      bus.act_last_o  <= 1'b0;
      bus.act_data_o  <= '0;
      bus.act_addr_o  <= '0;
      bus.act_lane_o  <= '0;
    end else if (accept) begin
      bus.act_valid_o <= 1'b1;
      bus.act_last_o  <= bus.lane_last_i[grant];
      bus.act_data_o  <= bus.lane_data_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
      bus.act_addr_o  <= bus.lane_addr_i[int'(grant)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      bus.act_lane_o  <= grant;
    end else if (bus.act_ready_i) begin
      bus.act_valid_o <= 1'b0;
    end
  end

  // A last accepted together with start_i belongs to the new frame, hence
  // the clear is applied before OR-ing in the current completion.
  always_comb begin
    done_mask_next = start_i ? '0 : done_mask;
    if (accept_last) done_mask_next = done_mask_next | grant_onehot;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_mask    <= '0;
      frame_done_o <= 1'b0;
    end else if (&done_mask_next) begin
      done_mask    <= '0;
      frame_done_o <= 1'b1;
    end else begin
      done_mask    <= done_mask_next;
      frame_done_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      beat_cnt_o <= '0;
    else if (start_i)
      beat_cnt_o <= accept ? ADDRESS_WIDTH'(1) : '0;
    else if (accept && !(&beat_cnt_o))
      beat_cnt_o <= beat_cnt_o + 1'b1;
  end
endmodule
